mips_mem_arbiter: RTL

- Shares one single-ported unified instruction/data memory between the IF stage (fetch) and the MEM stage (load/store) of the 5-stage MIPS pipeline (mipspipe).
- Sequences each access through a fixed-latency memory, returns read data and a one-cycle done pulse, and drives the IF and MEM stall lines to the pipeline.
- The data side has priority, and a streak limit prevents fetch starvation.

---
 rtl/mips_mem_pkg.sv | 20 ++
 rtl/mips_mem_arbiter_if.sv | 41 ++++
 rtl/mips_mem_arbiter.sv | 128 ++++++++++++
 3 files changed

// File: rtl/mips_mem_pkg.sv
// Shared types for the MIPS unified-memory arbiter: FSM states, access owner
// and the width of the latency and streak counters.
package mips_mem_pkg;

  localparam int LAT_W = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    NONE = 2'd0,
    INST = 2'd1,
    DATA = 2'd2
  } owner_e;

endpackage

// File: rtl/mips_mem_arbiter_if.sv
// Pipeline-side (fetch/data) and memory-side signals of the arbiter.
// slave is the arbiter's view; master is the pipeline plus memory.
interface mips_mem_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);

  logic          if_req;
  logic [AW-1:0] if_addr;
  logic [DW-1:0] if_rdata;
  logic          if_done;

  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_done;

  logic          stall_if;
  logic          stall_mem;

  logic          m_en;
  logic          m_we;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  logic [DW-1:0] m_rdata;

  modport slave (
    input  if_req, if_addr, mem_req, mem_we, mem_addr, mem_wdata, m_rdata,
    output if_rdata, if_done, mem_rdata, mem_done, stall_if, stall_mem,
           m_en, m_we, m_addr, m_wdata
  );

  modport master (
    output if_req, if_addr, mem_req, mem_we, mem_addr, mem_wdata, m_rdata,
    input  if_rdata, if_done, mem_rdata, mem_done, stall_if, stall_mem,
           m_en, m_we, m_addr, m_wdata
  );

endinterface

// File: rtl/mips_mem_arbiter.sv
// Shares one fixed-latency unified memory between IF (fetch) and MEM (load/store).
// Data has priority; a consecutive-data-grant streak limit keeps fetch from starving.
module mips_mem_arbiter
  import mips_mem_pkg::*;
#(
  parameter int AW          = 32,
  parameter int DW          = 32,
  parameter int RD_LAT      = 2,
  parameter int MAX_DSTREAK = 4
) (
  input  logic              clock,
  input  logic              reset_n,
  mips_mem_arbiter_if.slave bus
);

  localparam logic [LAT_W-1:0] LP_RD_LAT  = LAT_W'(RD_LAT);
  localparam logic [LAT_W-1:0] LP_MAX_STK = LAT_W'(MAX_DSTREAK);

  state_e           r_state;
  state_e           w_state_nxt;
  owner_e           r_owner;
  logic             w_grant_data;
  logic             w_grant_inst;
  logic             w_complete;
  logic [LAT_W-1:0] r_lat_cnt;
  logic [LAT_W-1:0] r_streak;

  logic             r_m_en;
  logic             r_m_we;
  logic             r_store;
  logic [AW-1:0]    r_m_addr;
  logic [DW-1:0]    r_m_wdata;
  logic             r_if_done;
  logic             r_mem_done;
  logic [DW-1:0]    r_if_rdata;
  logic [DW-1:0]    r_mem_rdata;

  assign w_complete = (r_state == WAIT) && (r_lat_cnt == LAT_W'(1));

  // NOTE: every output of this block gets a default first, so no path leaves
  // a signal unassigned and no latch is inferred.
  always_comb begin
    w_state_nxt  = r_state;
    w_grant_data = 1'b0;
    w_grant_inst = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (bus.mem_req && (!bus.if_req || (r_streak < LP_MAX_STK))) begin
          w_grant_data = 1'b1;
          w_state_nxt  = ISSUE;
        end else if (bus.if_req) begin
          w_grant_inst = 1'b1;
          w_state_nxt  = ISSUE;
        end
      end
      ISSUE:   w_state_nxt = WAIT;
      WAIT:    if (w_complete) w_state_nxt = DONE;
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_state_nxt;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_owner     <= NONE;
      r_lat_cnt   <= '0;
      r_streak    <= '0;
      r_m_en      <= 1'b0;
      r_m_we      <= 1'b0;
      r_store     <= 1'b0;
      r_m_addr    <= '0;
      r_m_wdata   <= '0;
      r_if_done   <= 1'b0;
      r_mem_done  <= 1'b0;
      r_if_rdata  <= '0;
      r_mem_rdata <= '0;
    end else begin
      // Strobe and write enable are high only for the single ISSUE cycle.
      r_m_en     <= w_grant_data | w_grant_inst;
      r_m_we     <= w_grant_data & bus.mem_we;
      r_if_done  <= w_complete && (r_owner == INST);
      r_mem_done <= w_complete && (r_owner == DATA);

      if (w_grant_data) begin
        r_owner   <= DATA;
        r_m_addr  <= bus.mem_addr;
        r_m_wdata <= bus.mem_wdata;
        r_store   <= bus.mem_we;
        // Streak only counts data grants that made a waiting fetch wait longer.
        if (!bus.if_req)                r_streak <= '0;
        else if (r_streak != LP_MAX_STK) r_streak <= r_streak + 1'b1;
      end else if (w_grant_inst) begin
        r_owner  <= INST;
        r_m_addr <= bus.if_addr;
        r_store  <= 1'b0;
        r_streak <= '0;
      end else if (r_state == DONE) begin
        r_owner <= NONE;
      end

      if (r_state == ISSUE)     r_lat_cnt <= LP_RD_LAT;
      else if (r_state == WAIT) r_lat_cnt <= r_lat_cnt - 1'b1;

      if (w_complete && (r_owner == INST)) r_if_rdata <= bus.m_rdata;
      // A store completion leaves the last load result visible.
      if (w_complete && (r_owner == DATA) && !r_store) r_mem_rdata <= bus.m_rdata;
    end
  end

  assign bus.m_en      = r_m_en;
  assign bus.m_we      = r_m_we;
  assign bus.m_addr    = r_m_addr;
  assign bus.m_wdata   = r_m_wdata;
  assign bus.if_done   = r_if_done;
  assign bus.mem_done  = r_mem_done;
  assign bus.if_rdata  = r_if_rdata;
  assign bus.mem_rdata = r_mem_rdata;
  assign bus.stall_if  = bus.if_req & ~r_if_done;
  assign bus.stall_mem = bus.mem_req & ~r_mem_done;

endmodule
